layer_weighted_sum: RTL and testbench

Upstream stage of the activation LUT block. Computes the pre-activation sum of each neuron in one layer from the previous layer's activations and a weight set, using one multiplier per neuron time-multiplexed over the inputs. Each sum is scaled, saturated and converted to an offset-binary LUT address. The result is a flat address bus that drives the activation stage's `inputs` directly. Outputs change only on completion, so the downstream `stable` detection sees a single clean transition.

---
 rtl/layer_weighted_sum.sv | 122 ++++++++++++
 tb/tb_layer_weighted_sum.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_weighted_sum.sv
// rtl/layer_weighted_sum.sv - time-multiplexed per-neuron weighted sum producing offset-binary LUT addresses
// One signed MAC per neuron walks the latched inputs; the scaled, saturated sums land on the bus together.
module layer_weighted_sum #(
    parameter int NUM_INPUTS    = 6,
    parameter int NUM_NEURON    = 6,
    parameter int INPUT_WIDTH   = 9,
    parameter int WEIGHT_WIDTH  = 10,
    parameter int ACC_WIDTH     = 24,
    parameter int FRAC_BITS     = 9,
    parameter int LUT_ADDR_SIZE = 10
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [NUM_INPUTS*INPUT_WIDTH-1:0]          inputs,
    input  logic [NUM_NEURON*NUM_INPUTS*WEIGHT_WIDTH-1:0] weights,
    output logic [NUM_NEURON*LUT_ADDR_SIZE-1:0]        outputs,
    output logic                                       busy,
    output logic                                       valid
);
    localparam int PROD_W = INPUT_WIDTH + 1 + WEIGHT_WIDTH;
    localparam int CNT_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);
    localparam logic [LUT_ADDR_SIZE-1:0] ZERO_ADDR = {1'b1, {(LUT_ADDR_SIZE-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (LUT_ADDR_SIZE-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 << (LUT_ADDR_SIZE-1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_WRITE
    } state_t;

    state_t                                      state_q;
    logic [CNT_W-1:0]                            cnt_q;
    logic [NUM_INPUTS*INPUT_WIDTH-1:0]           in_buf_q;
    logic [NUM_NEURON*NUM_INPUTS*WEIGHT_WIDTH-1:0] w_buf_q;
    logic signed [ACC_WIDTH-1:0]                 acc_q [NUM_NEURON];
    logic signed [ACC_WIDTH-1:0]                 acc_d [NUM_NEURON];
    logic [NUM_NEURON*LUT_ADDR_SIZE-1:0]         outputs_q;
    logic [NUM_NEURON*LUT_ADDR_SIZE-1:0]         outputs_d;
    logic                                        busy_q;
    logic                                        valid_q;

    logic signed [INPUT_WIDTH:0]                 in_s;
    logic signed [WEIGHT_WIDTH-1:0]              w_s;
    logic signed [PROD_W-1:0]                    prod;
    logic signed [ACC_WIDTH-1:0]                 shifted;

    always_comb begin
        in_s      = {1'b0, in_buf_q[int'(cnt_q)*INPUT_WIDTH +: INPUT_WIDTH]};
        w_s       = '0;
        prod      = '0;
        shifted   = '0;
        outputs_d = outputs_q;
        for (int n = 0; n < NUM_NEURON; n++) begin
            w_s      = w_buf_q[(n*NUM_INPUTS + int'(cnt_q))*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            prod     = PROD_W'(in_s) * PROD_W'(w_s);
            acc_d[n] = acc_q[n] + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};

            // Adding 2^(L-1) to an in-range L-bit two's-complement value just flips its MSB.
            shifted = acc_q[n] >>> FRAC_BITS;
            if (shifted > SAT_MAX) begin
                outputs_d[n*LUT_ADDR_SIZE +: LUT_ADDR_SIZE] = '1;
            end else if (shifted < SAT_MIN) begin
                outputs_d[n*LUT_ADDR_SIZE +: LUT_ADDR_SIZE] = '0;
            end else begin
                outputs_d[n*LUT_ADDR_SIZE +: LUT_ADDR_SIZE] =
                    {~shifted[LUT_ADDR_SIZE-1], shifted[LUT_ADDR_SIZE-2:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            in_buf_q  <= '0;
            w_buf_q   <= '0;
            for (int n = 0; n < NUM_NEURON; n++) acc_q[n] <= '0;
            outputs_q <= {NUM_NEURON{ZERO_ADDR}};
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        in_buf_q <= inputs;
                        w_buf_q  <= weights;
                        for (int n = 0; n < NUM_NEURON; n++) acc_q[n] <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    outputs_q <= outputs_d;
                    valid_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign outputs = outputs_q;
    assign busy    = busy_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_layer_weighted_sum.sv
// tb/tb_layer_weighted_sum.sv - scoreboard bench for layer_weighted_sum
// Driver pushes model results and due cycles; the negedge monitor pops them whenever valid is seen.
module tb_layer_weighted_sum;
    localparam int NI = 6;
    localparam int NN = 6;
    localparam int IW = 9;
    localparam int WW = 10;
    localparam int AW = 24;
    localparam int FB = 9;
    localparam int L  = 10;
    localparam logic [L-1:0] HALF_ADDR = L'(1 << (L-1));

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [NI*IW-1:0]      inputs_r;
    logic [NN*NI*WW-1:0]   weights_r;
    logic [NN*L-1:0]       outputs;
    logic                  busy;
    logic                  valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [NN*L-1:0] exp_out_q [$];
    int              exp_cyc_q [$];
    logic [NN*L-1:0] last_out;
    logic [NN*L-1:0] eo;
    int              ec;

    layer_weighted_sum #(
        .NUM_INPUTS(NI), .NUM_NEURON(NN), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW),
        .ACC_WIDTH(AW), .FRAC_BITS(FB), .LUT_ADDR_SIZE(L)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .inputs(inputs_r),
        .weights(weights_r), .outputs(outputs), .busy(busy), .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer dot product, floor division, clamp, offset.
    function automatic logic [NN*L-1:0] model(input logic [NI*IW-1:0] iv, input logic [NN*NI*WW-1:0] wv);
        logic [NN*L-1:0] r;
        longint sum, s, a, b, div, half;
        div  = longint'(1) << FB;
        half = longint'(1) << (L-1);
        r    = '0;
        for (int n = 0; n < NN; n++) begin
            sum = 0;
            for (int i = 0; i < NI; i++) begin
                a   = longint'(iv[i*IW +: IW]);
                b   = longint'($signed(wv[(n*NI+i)*WW +: WW]));
                sum = sum + a * b;
            end
            if (sum >= 0) s = sum / div;
            else          s = -((-sum + div - 1) / div);
            if (s > half - 1) s = half - 1;
            if (s < -half)    s = -half;
            r[n*L +: L] = L'(s + half);
        end
        return r;
    endfunction

    function automatic logic [NI*IW-1:0] rand_in();
        logic [NI*IW-1:0] v;
        for (int i = 0; i < NI; i++) v[i*IW +: IW] = IW'($urandom_range(0, (1 << IW) - 1));
        return v;
    endfunction

    function automatic logic [NN*NI*WW-1:0] rand_w();
        logic [NN*NI*WW-1:0] v;
        for (int k = 0; k < NN*NI; k++) v[k*WW +: WW] = WW'($urandom_range(0, (1 << WW) - 1));
        return v;
    endfunction

    function automatic logic [NN*NI*WW-1:0] fill_w(input logic [WW-1:0] val);
        logic [NN*NI*WW-1:0] v;
        for (int k = 0; k < NN*NI; k++) v[k*WW +: WW] = val;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called on a negedge; returns on the negedge after the start edge.
    task automatic issue(input logic [NI*IW-1:0] iv, input logic [NN*NI*WW-1:0] wv);
        inputs_r  = iv;
        weights_r = wv;
        start     = 1'b1;
        exp_out_q.push_back(model(iv, wv));
        exp_cyc_q.push_back(cyc + 8);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_out_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_out_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_out_q.size());
            exp_out_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", longint'(valid), 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_out = {NN{HALF_ADDR}};
        end else begin
            checks++;
            if (busy && valid) begin
                errors++;
                $display("FAIL busy_valid_overlap busy=%0b valid=%0b required=not_both", busy, valid);
            end
            if (valid) begin
                checks++;
                if (exp_out_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid cycle=%0d required=no_pulse", cyc);
                end else begin
                    eo = exp_out_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    if (outputs !== eo) begin
                        errors++;
                        $display("FAIL result actual=%h required=%h", outputs, eo);
                    end
                    checks++;
                    if (cyc != ec) begin
                        errors++;
                        $display("FAIL latency actual_cycle=%0d required_cycle=%0d", cyc, ec);
                    end
                end
            end else begin
                checks++;
                if (outputs !== last_out) begin
                    errors++;
                    $display("FAIL outputs_held actual=%h required=%h", outputs, last_out);
                end
            end
            last_out = outputs;
        end
    end

    initial begin
        logic [NI*IW-1:0]    iv;
        logic [NN*NI*WW-1:0] wv;
        rst       = 1'b1;
        start     = 1'b0;
        inputs_r  = '0;
        weights_r = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", longint'(outputs), longint'({NN{HALF_ADDR}}));
        chk("reset_busy", longint'(busy), 0);
        chk("reset_valid", longint'(valid), 0);

        // Zero inputs: every field at the zero-sum address, busy through the run.
        issue('0, rand_w());
        for (int k = 0; k < 7; k++) begin
            chk("busy_during_run", longint'(busy), 1);
            chk("no_early_valid", longint'(valid), 0);
            @(negedge clk);
        end
        chk("valid_at_e7", longint'(valid), 1);
        chk("busy_low_at_valid", longint'(busy), 0);
        wait_drain();

        iv = '0; iv[IW-1:0] = IW'(256);
        wv = '0;
        for (int n = 0; n < NN; n++) wv[(n*NI)*WW +: WW] = WW'(4);
        issue(iv, wv);
        wait_drain();

        issue('1, fill_w(WW'(511)));
        wait_drain();
        issue('1, fill_w(WW'(512)));
        wait_drain();

        iv = '0; iv[IW-1:0] = IW'(1);
        wv = '0; wv[WW-1:0] = '1;
        issue(iv, wv);
        wait_drain();

        // Start during busy plus mid-run input change, then back-to-back start in the valid cycle.
        iv = rand_in(); wv = rand_w();
        issue(iv, wv);
        @(negedge clk);
        start    = 1'b1;
        inputs_r = rand_in();
        weights_r = rand_w();
        @(negedge clk);
        start = 1'b0;
        wait_valid();
        issue(rand_in(), rand_w());
        wait_drain();

        // Reset during ACCUM aborts the run.
        issue(rand_in(), rand_w());
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_out_q.delete();
        exp_cyc_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_valid", longint'(valid), 0);
        chk("abort_outputs", longint'(outputs), longint'({NN{HALF_ADDR}}));
        repeat (12) @(negedge clk);
        issue(rand_in(), rand_w());
        wait_drain();

        for (int t = 0; t < 25; t++) begin
            iv = rand_in();
            wv = rand_w();
            if (t % 5 == 0) iv = '1;
            issue(iv, wv);
            wait_drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
